// File: rtl/sram_rd_streamer_if.sv
// Signal bundle between the SRAM read streamer, the SRAM pins it drives and
// the valid/ready stream it feeds toward the MAC array.
interface sram_rd_streamer_if #(
    parameter int BW = 32,
    parameter int AW = 4
);
    logic          START;
    logic [AW-1:0] BASE;
    logic [AW:0]   LEN;
    logic          BUSY;
    logic          DONE;
    logic          CSN;
    logic [AW-1:0] A;
    logic          WEN;
    logic [BW-1:0] DOUT_I;
    logic          O_VALID;
    logic [BW-1:0] O_DATA;
    logic          O_LAST;
    logic          O_READY;

    modport master (
        input  START, BASE, LEN, DOUT_I, O_READY,
        output BUSY, DONE, CSN, A, WEN, O_VALID, O_DATA, O_LAST
    );

    modport slave (
        output START, BASE, LEN, DOUT_I, O_READY,
        input  BUSY, DONE, CSN, A, WEN, O_VALID, O_DATA, O_LAST
    );
endinterface

// File: rtl/sram_rd_streamer.sv
// Streams LEN sequential SRAM words from BASE onto a valid/ready port; a
// 2-entry buffer plus an in-flight credit absorbs the 1-cycle read latency.
module sram_rd_streamer #(
    parameter int BW = 32,
    parameter int AW = 4
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    sram_rd_streamer_if.master   bus
);
    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_RUN  = 1'b1;
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] base_q,  base_d;
    logic [AW:0]   len_q,   len_d;
    logic [AW:0]   iss_q,   iss_d;
    logic [AW:0]   acc_q,   acc_d;
    logic [1:0]    occ_q,   occ_d;
    logic [BW-1:0] buf0_q,  buf0_d;
    logic [BW-1:0] buf1_q,  buf1_d;
    logic          done_q,  done_d;
    logic          infl_q;

    logic          run;
    logic          pop;
    logic          push;
    logic          issue;
    logic [2:0]    credit_use;

    // Slots already committed after this edge: held words plus the read in flight, minus the word leaving.
    always_comb begin
        run        = (state_q == S_RUN);
        pop        = (occ_q != 2'd0) && bus.O_READY;
        push       = infl_q;
        credit_use = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
        issue      = run && (iss_q < len_q) && (credit_use < 3'd2);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        iss_d   = iss_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        if (!run) begin
            if (bus.START) begin
                if (bus.LEN == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                    base_d  = bus.BASE;
                    len_d   = bus.LEN;
                    iss_d   = '0;
                    acc_d   = '0;
                end
            end
        end else begin
            if (issue) iss_d = iss_q + ONE;
            if (pop) begin
                acc_d = acc_q + ONE;
                if (acc_q == len_q - ONE) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = bus.DOUT_I;
                else               buf1_d = bus.DOUT_I;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = bus.DOUT_I;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.DOUT_I;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the buffer entries are reset too, because O_DATA must read 0 while RSTN is low.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            iss_q   <= '0;
            acc_q   <= '0;
            occ_q   <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            done_q  <= 1'b0;
            infl_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            iss_q   <= iss_d;
            acc_q   <= acc_d;
            occ_q   <= occ_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            done_q  <= done_d;
            infl_q  <= issue;
        end
    end

    assign bus.BUSY    = run;
    assign bus.DONE    = done_q;
    assign bus.CSN     = ~issue;
    assign bus.A       = base_q + iss_q[AW-1:0];
    assign bus.WEN     = 1'b1;
    assign bus.O_VALID = (occ_q != 2'd0);
    assign bus.O_DATA  = buf0_q;
    assign bus.O_LAST  = (occ_q != 2'd0) && (acc_q == len_q - ONE);

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        (occ_q != 2'd3) && !(push && !pop && occ_q == 2'd2));
endmodule

// File: tb/tb_sram_rd_streamer.sv
// Directed bench for sram_rd_streamer: an SRAM model, a transaction-level
// expectation model checked every cycle, and literal checks per scenario.
module tb_sram_rd_streamer;
    localparam int BW = 32;
    localparam int AW = 4;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    int   cyc  = 0;

    sram_rd_streamer_if #(.BW(BW), .AW(AW)) bus ();
    sram_rd_streamer #(.BW(BW), .AW(AW)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [BW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 + i;

    // Synchronous SRAM: read data appears after the edge that samples CSN low.
    always @(posedge CLK) if (!bus.CSN && bus.WEN) bus.DOUT_I <= mem[bus.A];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Consumer ready: held high, or cycling through 1,0,0,1,0,1.
    bit         ready_pat = 1'b0;
    logic [5:0] pat       = 6'b101001;
    int         ridx      = 0;
    always @(posedge CLK) begin
        #1;
        bus.O_READY = ready_pat ? pat[ridx % 6] : 1'b1;
        ridx++;
    end

    // Transaction model: the words and addresses still owed, and what the next edge must produce.
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    logic [31:0]   m_words[$];
    logic [AW-1:0] m_addrs[$];
    int            m_iss = 0;
    int            m_acc = 0;

    logic [31:0]   got_q[$];
    int            got_cyc[$];
    int            last_count = 0;
    int            first_csn_cyc = -1;
    int            first_valid_cyc = -1;
    int            done_cyc = -1;
    int            done_count = 0;
    bit            prev_stall = 1'b0;
    logic [31:0]   prev_data;
    logic          prev_last;

    always @(negedge CLK) begin
        if (!RSTN) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_words.delete();
            m_addrs.delete();
            prev_stall = 1'b0;
        end else begin
            automatic bit was_busy = m_busy;
            check("busy", bus.BUSY, m_busy);
            check("done", bus.DONE, m_done);
            check("wen", bus.WEN, 1'b1);
            if (bus.DONE) begin
                done_cyc = cyc;
                done_count++;
            end
            if (!m_busy) check("csn_idle", bus.CSN, 1'b1);
            else if (!bus.CSN) begin
                if (first_csn_cyc < 0) first_csn_cyc = cyc;
                if (m_addrs.size() == 0) check("extra_read", bus.CSN, 1'b1);
                else begin
                    check("addr", bus.A, m_addrs.pop_front());
                    m_iss++;
                end
            end
            if (prev_stall) begin
                check("stall_valid", bus.O_VALID, 1'b1);
                check("stall_data", bus.O_DATA, prev_data);
                check("stall_last", bus.O_LAST, prev_last);
            end
            if (!m_busy) check("valid_idle", bus.O_VALID, 1'b0);
            else if (bus.O_VALID) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (m_words.size() == 0) check("extra_word", bus.O_VALID, 1'b0);
                else begin
                    check("data", bus.O_DATA, m_words[0]);
                    check("last", bus.O_LAST, m_words.size() == 1);
                end
            end
            prev_stall = bus.O_VALID && !bus.O_READY;
            prev_data  = bus.O_DATA;
            prev_last  = bus.O_LAST;

            m_done = 1'b0;
            if (m_busy && bus.O_VALID && bus.O_READY && m_words.size() > 0) begin
                got_q.push_back(bus.O_DATA);
                got_cyc.push_back(cyc);
                if (bus.O_LAST) last_count++;
                void'(m_words.pop_front());
                m_acc++;
                if (m_words.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (was_busy) check("credits", (m_iss - m_acc) <= 2, 1'b1);
            else if (bus.START) begin
                if (bus.LEN == 0) m_done = 1'b1;
                else begin
                    m_busy = 1'b1;
                    m_iss  = 0;
                    m_acc  = 0;
                    for (int i = 0; i < int'(bus.LEN); i++) begin
                        automatic logic [AW-1:0] a = bus.BASE + AW'(i);
                        m_addrs.push_back(a);
                        m_words.push_back(mem[a]);
                    end
                end
            end
        end
    end

    int start_k;
    int done_base;

    task automatic start_xfer(input logic [AW-1:0] base, input logic [AW:0] len);
        @(posedge CLK);
        #1;
        got_q.delete();
        got_cyc.delete();
        last_count      = 0;
        first_csn_cyc   = -1;
        first_valid_cyc = -1;
        done_cyc        = -1;
        done_base       = done_count;
        start_k         = cyc + 1;
        bus.START = 1'b1;
        bus.BASE  = base;
        bus.LEN   = len;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && done_count == done_base; n++) @(posedge CLK);
        repeat (2) @(posedge CLK);
        check("done_seen_once", done_count - done_base, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csn"},   bus.CSN,     1'b1);
        check({tag, "_a"},     bus.A,       '0);
        check({tag, "_wen"},   bus.WEN,     1'b1);
        check({tag, "_busy"},  bus.BUSY,    1'b0);
        check({tag, "_done"},  bus.DONE,    1'b0);
        check({tag, "_valid"}, bus.O_VALID, 1'b0);
        check({tag, "_data"},  bus.O_DATA,  '0);
        check({tag, "_last"},  bus.O_LAST,  1'b0);
    endtask

    initial begin
        bus.START = 1'b0;
        bus.BASE  = '0;
        bus.LEN   = '0;
        #12;
        check_reset_outputs("por");
        @(posedge CLK);
        #1 RSTN = 1'b1;
        repeat (2) @(posedge CLK);

        // BASE=3 LEN=4, ready held high: timing and data pinned literally.
        start_xfer(4'd3, 5'd4);
        wait_done(40);
        check("t1_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check("t1_word", got_q[i], 32'hA000_0003 + i);
            check("t1_back2back", got_cyc[i] - got_cyc[0], i);
        end
        check("t1_csn_lat", first_csn_cyc - start_k, 0);
        check("t1_valid_lat", first_valid_cyc - start_k, 2);
        check("t1_done_lat", done_cyc - start_k, 6);
        check("t1_last_count", last_count, 1);
        check("t1_busy_after", bus.BUSY, 1'b0);

        // Address wrap past 15.
        start_xfer(4'd14, 5'd4);
        wait_done(40);
        check("t2_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("t2_w0", got_q[0], 32'hA000_000E);
            check("t2_w1", got_q[1], 32'hA000_000F);
            check("t2_w2", got_q[2], 32'hA000_0000);
            check("t2_w3", got_q[3], 32'hA000_0001);
        end

        // Same wrapped transfer under backpressure.
        ready_pat = 1'b1;
        start_xfer(4'd14, 5'd4);
        wait_done(80);
        ready_pat = 1'b0;
        check("t3_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("t3_w0", got_q[0], 32'hA000_000E);
            check("t3_w3", got_q[3], 32'hA000_0001);
        end
        check("t3_stalled", done_cyc - start_k > 6, 1'b1);

        // LEN=0: no reads, DONE in the cycle after START is sampled.
        start_xfer(4'd5, 5'd0);
        wait_done(10);
        check("t4_done_lat", done_cyc - start_k, 0);
        check("t4_no_csn", first_csn_cyc, -1);
        check("t4_no_valid", first_valid_cyc, -1);

        // Full-depth transfer.
        start_xfer(4'd0, 5'd16);
        wait_done(80);
        check("t5_count", got_q.size(), 16);
        if (got_q.size() == 16) begin
            check("t5_first", got_q[0], 32'hA000_0000);
            check("t5_final", got_q[15], 32'hA000_000F);
            check("t5_span", got_cyc[15] - got_cyc[0], 15);
        end
        check("t5_last_count", last_count, 1);
        check("t5_done_lat", done_cyc - start_k, 18);

        // Abort mid-transfer after two accepted words.
        start_xfer(4'd0, 5'd8);
        for (int n = 0; n < 40 && m_acc < 2; n++) @(posedge CLK);
        check("t6_two_accepted", m_acc, 2);
        #2 RSTN = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge CLK);
        #1 RSTN = 1'b1;
        done_base = done_count;
        repeat (6) @(posedge CLK);
        check("t6_no_done", done_count - done_base, 0);
        start_xfer(4'd0, 5'd2);
        wait_done(40);
        check("t6_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t6_w0", got_q[0], 32'hA000_0000);
            check("t6_w1", got_q[1], 32'hA000_0001);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
